// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply sequencer: FSM encoding,
// frame geometry defaults and the ROM/SRAM address widths.
package matmul_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PRE,
        S_MAC,
        S_WB,
        S_FIN
    } state_t;

    localparam int P_N_COL = 4;   // result columns per frame
    localparam int P_N_K   = 4;   // MAC cycles per column
    localparam int ROM_AW  = 4;
    localparam int RAM_AW  = 4;
    localparam int WB_N    = 4;   // SRAM words written per column
    localparam int SEL_W   = 2;
    localparam int MUL_W   = 3;
endpackage

// File: rtl/ctrl_timeout.sv
// LOAD watchdog: counts consecutive cycles the sequencer will spend in LOAD and
// raises a registered one-cycle expiry during the LOAD_TO-th such cycle.
module ctrl_timeout #(
    parameter int LOAD_TO = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_expire
);
    localparam int CW = $clog2(LOAD_TO + 1);

    logic [CW-1:0] r_cnt;
    logic          r_expire;

    // i_en is "next cycle is a LOAD cycle", so r_cnt equals the 1-based LOAD
    // cycle number and r_expire lines up with the cycle it reports.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_expire <= 1'b0;
        end else if (i_en) begin
            r_cnt    <= r_cnt + CW'(1);
            r_expire <= (r_cnt == CW'(LOAD_TO - 1));
        end else begin
            r_cnt    <= '0;
            r_expire <= 1'b0;
        end
    end

    assign o_expire = r_expire;
endmodule

// File: rtl/matmul_ctrl.sv
// Frame sequencer for the matmul datapath: X load, per-column ROM prefetch and
// MAC, then a ready-gated SRAM write-back of WB_N words per column.
module matmul_ctrl
    import matmul_pkg::*;
#(
    parameter int N_COL   = P_N_COL,
    parameter int N_K     = P_N_K,
    parameter int LOAD_TO = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              xload_done,
    input  logic              ry,
    output logic              input_load_en,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              AU_en,
    output logic              acc_clr,
    output logic [MUL_W-1:0]  count_mul,
    output logic              ram_cs_n,
    output logic              ram_we_n,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [SEL_W-1:0]  wb_sel,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int CW = (N_COL > 1) ? $clog2(N_COL) : 1;
    localparam int KW = (N_K > 1) ? $clog2(N_K) : 1;
    localparam int IW = $clog2(WB_N);

    state_t            r_state, w_nxt_state;
    logic [CW-1:0]     r_col, w_col;
    logic [KW-1:0]     r_k, w_k;
    logic [IW-1:0]     r_i, w_i;
    logic              w_expire, w_wr;

    logic              r_load_en, w_load_en;
    logic [ROM_AW-1:0] r_rom_addr, w_rom_addr;
    logic              r_au_en, w_au_en;
    logic              r_acc_clr, w_acc_clr;
    logic [MUL_W-1:0]  r_count_mul, w_count_mul;
    logic              r_wr_n;
    logic [RAM_AW-1:0] r_ram_addr, w_ram_addr;
    logic [SEL_W-1:0]  r_wb_sel, w_wb_sel;
    logic              r_busy, w_busy;
    logic              r_done, w_done;

    ctrl_timeout #(.LOAD_TO(LOAD_TO)) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .i_en     (w_nxt_state == S_LOAD),
        .o_expire (w_expire)
    );

    always_comb begin
        w_nxt_state = r_state;
        w_col       = r_col;
        w_k         = r_k;
        w_i         = r_i;
        case (r_state)
            S_IDLE: if (start) begin
                w_nxt_state = S_LOAD;
                w_col       = '0;
                w_k         = '0;
                w_i         = '0;
            end
            S_LOAD: begin
                if (w_expire)        w_nxt_state = S_IDLE;
                else if (xload_done) w_nxt_state = S_PRE;
            end
            S_PRE: begin
                w_nxt_state = S_MAC;
                w_k         = '0;
            end
            S_MAC: begin
                if (r_k == KW'(N_K - 1)) begin
                    w_nxt_state = S_WB;
                    w_i         = '0;
                end else begin
                    w_k = r_k + KW'(1);
                end
            end
            // Progress only after a write cycle has actually been issued.
            S_WB: if (!r_wr_n) begin
                if (r_i == IW'(WB_N - 1)) begin
                    if (r_col == CW'(N_COL - 1)) begin
                        w_nxt_state = S_FIN;
                    end else begin
                        w_nxt_state = S_PRE;
                        w_col       = r_col + CW'(1);
                        w_k         = '0;
                    end
                end else begin
                    w_i = r_i + IW'(1);
                end
            end
            S_FIN:   w_nxt_state = S_IDLE;
            default: w_nxt_state = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line
    // up with the state they describe; ry sampled at an edge opens the write.
    always_comb begin
        w_wr        = (w_nxt_state == S_WB) && ry;
        w_load_en   = (w_nxt_state == S_LOAD);
        w_au_en     = (w_nxt_state == S_MAC);
        w_acc_clr   = (w_nxt_state == S_PRE);
        w_busy      = (w_nxt_state != S_IDLE);
        w_done      = (w_nxt_state == S_FIN);
        w_count_mul = (w_nxt_state == S_MAC) ? MUL_W'(w_k) : '0;
        w_rom_addr  = r_rom_addr;
        w_ram_addr  = r_ram_addr;
        w_wb_sel    = r_wb_sel;
        if (w_nxt_state == S_PRE) begin
            w_rom_addr = ROM_AW'(int'(w_col) * N_K);
        end else if (w_nxt_state == S_MAC) begin
            w_rom_addr = ROM_AW'(int'(w_col) * N_K +
                         ((w_k == KW'(N_K - 1)) ? int'(w_k) : int'(w_k) + 1));
        end
        if (w_wr) begin
            w_ram_addr = RAM_AW'(int'(w_col) * WB_N + int'(w_i));
            w_wb_sel   = SEL_W'(w_i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_col       <= '0;
            r_k         <= '0;
            r_i         <= '0;
            r_load_en   <= 1'b0;
            r_rom_addr  <= '0;
            r_au_en     <= 1'b0;
            r_acc_clr   <= 1'b0;
            r_count_mul <= '0;
            r_wr_n      <= 1'b1;
            r_ram_addr  <= '0;
            r_wb_sel    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_col       <= w_col;
            r_k         <= w_k;
            r_i         <= w_i;
            r_load_en   <= w_load_en;
            r_rom_addr  <= w_rom_addr;
            r_au_en     <= w_au_en;
            r_acc_clr   <= w_acc_clr;
            r_count_mul <= w_count_mul;
            r_wr_n      <= ~w_wr;
            r_ram_addr  <= w_ram_addr;
            r_wb_sel    <= w_wb_sel;
            r_busy      <= w_busy;
            r_done      <= w_done;
        end
    end

    assign input_load_en = r_load_en;
    assign rom_addr      = r_rom_addr;
    assign AU_en         = r_au_en;
    assign acc_clr       = r_acc_clr;
    assign count_mul     = r_count_mul;
    assign ram_cs_n      = r_wr_n;
    assign ram_we_n      = r_wr_n;
    assign ram_addr      = r_ram_addr;
    assign wb_sel        = r_wb_sel;
    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = w_expire;
endmodule

// File: tb/tb_matmul_ctrl.sv
// Bench for matmul_ctrl: a per-cycle vector table for the opening of a frame
// and reset mid-MAC, then full frames, backpressure and LOAD timeout.
module tb_matmul_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1, start = 1'b0, xload_done = 1'b0, ry = 1'b0;
    logic       start_to = 1'b0, xload_to = 1'b0;
    logic       input_load_en, AU_en, acc_clr, ram_cs_n, ram_we_n, busy, done, err;
    logic [3:0] rom_addr, ram_addr;
    logic [2:0] count_mul;
    logic [1:0] wb_sel;
    logic       t_load_en, t_au, t_acc, t_cs_n, t_we_n, t_busy, t_done, t_err;
    logic [3:0] t_rom, t_ram;
    logic [2:0] t_cm;
    logic [1:0] t_sel;

    always #5 clk = ~clk;

    matmul_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .xload_done(xload_done), .ry(ry),
        .input_load_en(input_load_en), .rom_addr(rom_addr), .AU_en(AU_en),
        .acc_clr(acc_clr), .count_mul(count_mul), .ram_cs_n(ram_cs_n),
        .ram_we_n(ram_we_n), .ram_addr(ram_addr), .wb_sel(wb_sel),
        .busy(busy), .done(done), .err(err)
    );

    matmul_ctrl #(.LOAD_TO(8)) dut_to (
        .clk(clk), .rst(rst), .start(start_to), .xload_done(xload_to), .ry(ry),
        .input_load_en(t_load_en), .rom_addr(t_rom), .AU_en(t_au),
        .acc_clr(t_acc), .count_mul(t_cm), .ram_cs_n(t_cs_n),
        .ram_we_n(t_we_n), .ram_addr(t_ram), .wb_sel(t_sel),
        .busy(t_busy), .done(t_done), .err(t_err)
    );

    int n_chk = 0, n_err = 0;
    int cyc = 0, au_cnt, wr_cnt, done_cnt, err_cnt, pre_cnt, load_cnt, first_au, cap_n;
    int wr_cyc[16];
    int cap_rom[5];
    int cap_acc[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        bit rst, start, xd, ry;
        bit busy, lden, acc, au;
        int rom, cm;
        bit we_n;
        int addr, sel;
    } vec_t;

    function automatic vec_t mk(bit r, bit s, bit x, bit y, bit b, bit l, bit a, bit u,
                                int ro, int c, bit w, int ad, int se);
        vec_t v;
        v.rst = r; v.start = s; v.xd = x; v.ry = y;
        v.busy = b; v.lden = l; v.acc = a; v.au = u;
        v.rom = ro; v.cm = c; v.we_n = w; v.addr = ad; v.sel = se;
        return v;
    endfunction

    // One clock, then sample and update the frame statistics of dut.
    task automatic step();
        @(posedge clk); #1;
        cyc++;
        if (AU_en) begin
            if (au_cnt == 0) first_au = cyc;
            au_cnt++;
        end
        if (input_load_en) load_cnt++;
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (acc_clr) pre_cnt++;
        if (pre_cnt == 3 && cap_n < 5) begin
            cap_rom[cap_n] = int'(rom_addr);
            cap_acc[cap_n] = int'(acc_clr);
            cap_n++;
        end
        if (!ram_we_n) begin
            chk("wr_cs_n", ram_cs_n, 0);
            chk($sformatf("wr_addr[%0d]", wr_cnt), ram_addr, wr_cnt);
            chk($sformatf("wr_sel[%0d]", wr_cnt), wb_sel, wr_cnt % 4);
            if (wr_cnt < 16) wr_cyc[wr_cnt] = cyc;
            wr_cnt++;
        end
    endtask

    task automatic run_frame(input bit stall);
        int t_start, post, stall_left, stall_cyc;
        bit seen_done, poked;
        au_cnt = 0; wr_cnt = 0; done_cnt = 0; err_cnt = 0; pre_cnt = 0;
        load_cnt = 0; cap_n = 0; first_au = -1;
        post = 0; stall_left = 0; stall_cyc = 0; seen_done = 0; poked = 0;
        ry = 1'b1; xload_done = 1'b0; start = 1'b1;
        t_start = cyc;
        step();
        for (int c = 0; c < 600 && post < 4; c++) begin
            step();
            start = 1'b0;
            xload_done = (cyc - t_start >= 32);
            if (seen_done) begin
                post++;
                if (post == 1) begin
                    chk("busy_after_done", busy, 0);
                    chk("no_restart_after_fin", input_load_en, 0);
                end
            end
            if (done && !seen_done) begin
                seen_done = 1'b1;
                start = 1'b1;                       // start coincident with done
            end
            if (AU_en && au_cnt == 7 && !poked) begin
                start = 1'b1;                       // start during MAC
                poked = 1'b1;
            end
            if (stall && !ram_we_n && ram_addr == 4'd5) begin
                ry = 1'b0;
                stall_left = 5;
                stall_cyc = cyc;
            end else if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) ry = 1'b1;
            end
        end
        start = 1'b0;
        chk("frame_done_seen", seen_done, 1);
        chk("au_cycles", au_cnt, 16);
        chk("writes", wr_cnt, 16);
        chk("done_pulses", done_cnt, 1);
        chk("err_pulses", err_cnt, 0);
        chk("load_cycles", load_cnt, 32);
        chk("start_to_au_latency", first_au - t_start, load_cnt + 2);
        if (stall) chk("stall_write6_gap", wr_cyc[6] - stall_cyc, 6);
        else begin
            for (int j = 0; j < 5; j++) begin
                chk($sformatf("col2_rom[%0d]", j), cap_rom[j], 8 + ((j < 4) ? j : 3));
                chk($sformatf("col2_acc[%0d]", j), cap_acc[j], (j == 0) ? 1 : 0);
            end
        end
    endtask

    vec_t vecs[21];

    initial begin
        int t_err_n, t_err_at, t_au_n;
        //              rst st xd ry  bsy ld acc au  rom cm we_n addr sel
        vecs[0]  = mk(1, 0, 0, 0,  0, 0, 0, 0,  0, 0, 1, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 1, 0, 0);
        vecs[2]  = mk(0, 1, 0, 0,  1, 1, 0, 0,  0, 0, 1, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0,  1, 1, 0, 0,  0, 0, 1, 0, 0);
        vecs[4]  = mk(0, 0, 1, 0,  1, 0, 1, 0,  0, 0, 1, 0, 0);
        vecs[5]  = mk(0, 0, 0, 0,  1, 0, 0, 1,  1, 0, 1, 0, 0);
        vecs[6]  = mk(0, 0, 0, 0,  1, 0, 0, 1,  2, 1, 1, 0, 0);
        vecs[7]  = mk(0, 0, 0, 0,  1, 0, 0, 1,  3, 2, 1, 0, 0);
        vecs[8]  = mk(0, 0, 0, 0,  1, 0, 0, 1,  3, 3, 1, 0, 0);
        vecs[9]  = mk(0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 1, 0, 0);
        vecs[10] = mk(0, 0, 0, 1,  1, 0, 0, 0,  0, 0, 0, 0, 0);
        vecs[11] = mk(0, 0, 0, 1,  1, 0, 0, 0,  0, 0, 0, 1, 1);
        vecs[12] = mk(0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 1, 0, 0);
        vecs[13] = mk(0, 0, 0, 1,  1, 0, 0, 0,  0, 0, 0, 2, 2);
        vecs[14] = mk(0, 0, 0, 1,  1, 0, 0, 0,  0, 0, 0, 3, 3);
        vecs[15] = mk(0, 0, 0, 1,  1, 0, 1, 0,  4, 0, 1, 0, 0);
        vecs[16] = mk(0, 0, 0, 1,  1, 0, 0, 1,  5, 0, 1, 0, 0);
        vecs[17] = mk(0, 0, 0, 1,  1, 0, 0, 1,  6, 1, 1, 0, 0);
        vecs[18] = mk(0, 0, 0, 1,  1, 0, 0, 1,  7, 2, 1, 0, 0);
        vecs[19] = mk(1, 0, 0, 1,  0, 0, 0, 0,  0, 0, 1, 0, 0);  // reset at col 1, k=2
        vecs[20] = mk(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 1, 0, 0);

        for (int v = 0; v < 21; v++) begin
            rst = vecs[v].rst; start = vecs[v].start;
            xload_done = vecs[v].xd; ry = vecs[v].ry;
            @(posedge clk); #1;
            chk($sformatf("tbl[%0d].busy", v), busy, vecs[v].busy);
            chk($sformatf("tbl[%0d].load_en", v), input_load_en, vecs[v].lden);
            chk($sformatf("tbl[%0d].acc_clr", v), acc_clr, vecs[v].acc);
            chk($sformatf("tbl[%0d].AU_en", v), AU_en, vecs[v].au);
            chk($sformatf("tbl[%0d].we_n", v), ram_we_n, vecs[v].we_n);
            chk($sformatf("tbl[%0d].cs_n", v), ram_cs_n, vecs[v].we_n);
            chk($sformatf("tbl[%0d].done", v), done, 0);
            chk($sformatf("tbl[%0d].err", v), err, 0);
            if (vecs[v].au || vecs[v].acc || vecs[v].rst) begin
                chk($sformatf("tbl[%0d].rom_addr", v), rom_addr, vecs[v].rom);
                chk($sformatf("tbl[%0d].count_mul", v), count_mul, vecs[v].cm);
            end
            if (!vecs[v].we_n || vecs[v].rst) begin
                chk($sformatf("tbl[%0d].ram_addr", v), ram_addr, vecs[v].addr);
                chk($sformatf("tbl[%0d].wb_sel", v), wb_sel, vecs[v].sel);
            end
        end

        // Fresh frame right after the mid-MAC reset, with prefetch trace and
        // start pokes during MAC and FIN; then a frame with SRAM backpressure.
        run_frame(1'b0);
        repeat (3) step();
        run_frame(1'b1);

        // LOAD timeout on the LOAD_TO=8 instance.
        t_err_n = 0; t_err_at = 0; t_au_n = 0;
        chk("to_reset_busy", t_busy, 0);
        chk("to_reset_cs_n", t_cs_n, 1);
        start_to = 1'b1;
        @(posedge clk); #1;
        start_to = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (t_err) begin t_err_n++; t_err_at = c; end
            if (t_au) t_au_n++;
            if (c == 8) chk("to_load_en_c8", t_load_en, 1);
            if (c == 9) chk("to_idle_c9", t_busy, 0);
            @(posedge clk); #1;
        end
        chk("to_err_pulses", t_err_n, 1);
        chk("to_err_cycle", t_err_at, 8);
        chk("to_no_au", t_au_n, 0);
        chk("to_done", t_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/matmul_ctrl.md
MATMUL_CTRL -- requirements
Module: matmul_ctrl

Interface
REQ-001 SHALL have parameters: N_COL, default 4, result columns per frame; N_K, default 4, MAC cycles per column; LOAD_TO, default 255, LOAD timeout in cycles.
REQ-002 SHALL have ports: clk in 1, single clock, rising edge; rst in 1, synchronous active-high reset.
REQ-003 SHALL have ports: start in 1, frame request pulse; xload_done in 1, X buffer full; ry in 1, SRAM ready.
REQ-004 SHALL have ports: input_load_en out 1, rom_addr out 4, AU_en out 1, acc_clr out 1, count_mul out 3.
REQ-005 SHALL have ports: ram_cs_n out 1, ram_we_n out 1, ram_addr out 4, wb_sel out 2, busy out 1, done out 1, err out 1.

Function
REQ-006 SHALL implement states IDLE, LOAD, PRE, MAC, WB, FIN.
REQ-007 IDLE: start=1 SHALL go to LOAD and clear col, k and i; start SHALL be ignored in every other state.
REQ-008 LOAD: input_load_en SHALL be 1.
REQ-009 LOAD: xload_done=1 SHALL go to PRE.
REQ-010 LOAD: LOAD_TO cycles without xload_done SHALL pulse err for 1 cycle and go to IDLE.
REQ-011 PRE: one cycle; rom_addr SHALL be {col,k=0} to cover the 1-cycle registered ROM latency; acc_clr SHALL be 1; AU_en SHALL be 0.
REQ-012 MAC: AU_en SHALL be 1 for exactly N_K cycles; count_mul SHALL equal k, zero-extended.
REQ-013 MAC: rom_addr SHALL be {col,k+1}, prefetch; on the last MAC cycle rom_addr SHALL hold its value.
REQ-014 After k=N_K-1, MAC SHALL go to WB with i=0.
REQ-015 WB: when ry=1, ram_cs_n=0, ram_we_n=0, wb_sel=i and ram_addr={col,i} SHALL be driven for one cycle, then i SHALL increment.
REQ-016 WB: when ry=0, no write SHALL be issued and i SHALL hold; waiting is unbounded.
REQ-017 WB: after the write with i=3, if col=N_COL-1 the block SHALL go to FIN, otherwise col SHALL increment and the block SHALL go to PRE.
REQ-018 FIN: done SHALL pulse for 1 cycle, then the block SHALL go to IDLE.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 ram_cs_n and ram_we_n SHALL be 1 outside write cycles; a write SHALL never occur outside WB.
REQ-021 All outputs SHALL be registered; latency from start to first AU_en SHALL be (LOAD cycles + 2).
REQ-022 Simultaneous start and done: start SHALL be ignored, because FIN is not IDLE.
REQ-023 col and k SHALL never wrap beyond N_COL-1 and N_K-1 respectively.

Reset
REQ-024 rst=1 SHALL force IDLE at the next clock edge.
REQ-025 Reset values SHALL be: col=k=i=0; rom_addr=0; count_mul=0; wb_sel=0; ram_addr=0; ram_cs_n=1; ram_we_n=1; all other outputs 0.
REQ-026 rst asserted mid-frame (any state) SHALL abort the frame with no further SRAM write and no done pulse.

Structure
REQ-027 The state encoding, N_COL, N_K and the ROM/SRAM address widths SHALL live in shared package matmul_pkg.
REQ-028 The LOAD timeout counter SHALL be a sub-module ctrl_timeout; the FSM and all counters SHALL stay in matmul_ctrl.

Verification
REQ-029 Normal frame: start, xload_done after 32 cycles, ry=1 -> AU_en high 4x4=16 cycles; 16 writes to ram_addr 0..15 in order; done pulses once; busy falls the cycle after done.
REQ-030 Prefetch: in column 2, rom_addr sequence SHALL be 8 (PRE), 9, 10, 11, 11, with acc_clr=1 only in PRE.
REQ-031 Backpressure: ry=0 for 5 cycles at i=2 of column 1 -> no ram_we_n pulse during the stall; the write to ram_addr 6 occurs on the first cycle with ry=1.
REQ-032 Timeout: LOAD_TO=8 and xload_done held 0 -> err pulses at the 8th LOAD cycle; return to IDLE; no AU_en.
REQ-033 Reset mid-MAC: rst during column 1, k=2 -> next cycle IDLE, outputs at reset values; a new start then runs a full frame from ram_addr 0.
REQ-034 Start ignored: start pulsed during MAC and during FIN -> no restart; exactly one done.
